iu_bpred: RTL and testbench

IU_BPRED -- requirements
Module: iu_bpred

---
 rtl/iu_bpred_if.sv | 21 ++
 rtl/iu_bpred.sv | 81 ++++++++
 tb/tb_iu_bpred.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/iu_bpred_if.sv
// iu_bpred_if: redirect, BTB training and next-PC handshake bus of the branch predictor
interface iu_bpred_if #(parameter int XLEN = 64);
    logic            miss;
    logic [XLEN-1:0] pc_curr;
    logic [31:0]     insn_curr;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            pc_pre_ready;
    logic [XLEN-1:0] pc_pre;
    logic            pc_pre_valid;
    logic            busy;
    modport master (
        output miss, pc_curr, insn_curr, upd_valid, upd_pc, upd_target, pc_pre_ready,
        input  pc_pre, pc_pre_valid, busy
    );
    modport slave (
        input  miss, pc_curr, insn_curr, upd_valid, upd_pc, upd_target, pc_pre_ready,
        output pc_pre, pc_pre_valid, busy
    );
endinterface

// File: rtl/iu_bpred.sv
// iu_bpred: multi-cycle next-PC predictor with static branch rules and a direct-mapped BTB
module iu_bpred #(
    parameter int XLEN        = 64,
    parameter int WORK_PERIOD = 6,
    parameter int BTB_ENTRIES = 16
) (
    input logic       clk,
    input logic       rst_n,
    iu_bpred_if.slave bus
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 2;
    typedef enum logic [2:0] {IDLE = 3'b001, WORK = 3'b010, HOLD = 3'b100} state_t;
    state_t          state, state_nxt;
    logic [7:0]      cnt;
    logic [XLEN-1:0] cpc, pc_pre_q, pred, seq4, btb_pc, j_imm, b_imm;
    logic [31:0]     insn;
    logic            insn_vld, hit, last, accept, unused_bits;
    logic [IW-1:0]   rd_idx, wr_idx;
    logic [BTB_ENTRIES-1:0] btb_vld;
    logic [TW-1:0]   btb_tag [BTB_ENTRIES];
    logic [XLEN-1:0] btb_tgt [BTB_ENTRIES];
    assign rd_idx      = cpc[IW+1:2];
    assign wr_idx      = bus.upd_pc[IW+1:2];
    assign unused_bits = ^bus.upd_pc[1:0];
    // lookup reads the array before this edge's training write lands
    assign hit    = btb_vld[rd_idx] && btb_tag[rd_idx] == cpc[XLEN-1:IW+2];
    assign seq4   = cpc + XLEN'(4);
    assign btb_pc = hit ? btb_tgt[rd_idx] : seq4;
    assign j_imm  = {{(XLEN-20){insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    assign b_imm  = {{(XLEN-12){insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
    assign pred   = !insn_vld                 ? btb_pc :
                    insn[1:0] != 2'b11        ? cpc + XLEN'(2) :
                    insn[6:0] == 7'b1101111   ? cpc + j_imm :
                    insn[6:0] == 7'b1100011   ? (insn[31] ? cpc + b_imm : seq4) :
                    insn[6:0] == 7'b1100111   ? btb_pc : seq4;
    assign last   = cnt == 8'(WORK_PERIOD - 1);
    assign accept = state == HOLD && bus.pc_pre_ready && !bus.miss;
    always_comb begin
        state_nxt = state;
        state_nxt = (bus.miss || accept) ? WORK : (state == WORK && last) ? HOLD : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            cpc      <= '0;
            insn     <= '0;
            insn_vld <= 1'b0;
            pc_pre_q <= '0;
        end else if (bus.miss) begin
            cpc      <= bus.pc_curr;
            insn     <= bus.insn_curr;
            insn_vld <= 1'b1;
            cnt      <= '0;
        end else if (accept) begin
            cpc      <= pc_pre_q;
            insn_vld <= 1'b0;
            cnt      <= '0;
        end else if (state == WORK) begin
            cnt <= cnt + 8'd1;
            if (last) pc_pre_q <= pred;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             btb_vld         <= '0;
        else if (bus.upd_valid) btb_vld[wr_idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (bus.upd_valid) begin
            btb_tag[wr_idx] <= bus.upd_pc[XLEN-1:IW+2];
            btb_tgt[wr_idx] <= bus.upd_target;
        end
    end
    assign bus.pc_pre_valid = state == HOLD;
    assign bus.pc_pre       = state == HOLD ? pc_pre_q : '0;
    assign bus.busy         = state == WORK;
endmodule

// File: tb/tb_iu_bpred.sv
// tb_iu_bpred: directed and random checks of iu_bpred against an event-timeline reference model
module tb_iu_bpred;
    localparam int XLEN = 64;
    localparam int WP   = 6;
    localparam int N    = 16;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad   = 0;
    always #5 clk = ~clk;
    iu_bpred_if #(.XLEN(XLEN)) bus ();
    iu_bpred #(.XLEN(XLEN), .WORK_PERIOD(WP), .BTB_ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    // model: a prediction becomes visible WP edges after the redirect/accept that started it
    logic        m_valid = 1'b0, m_active = 1'b0, m_ivld = 1'b0;
    logic [63:0] m_pc = '0, m_base = '0;
    logic [31:0] m_insn = '0;
    longint      e = 0, due = 0;
    logic        bv  [N];
    logic [63:0] bpc [N];
    logic [63:0] btg [N];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] predict();
        int          i;
        logic [63:0] btb_or_seq;
        longint      imm;
        i = int'(m_base[5:2]);
        btb_or_seq = (bv[i] && bpc[i][63:2] == m_base[63:2]) ? btg[i] : m_base + 64'd4;
        if (!m_ivld) return btb_or_seq;
        if (m_insn[1:0] != 2'b11) return m_base + 64'd2;
        if (m_insn[6:0] == 7'h6F) begin
            imm = longint'($signed({m_insn[31], m_insn[19:12], m_insn[20], m_insn[30:21], 1'b0}));
            return m_base + 64'(imm);
        end
        if (m_insn[6:0] == 7'h63) begin
            imm = longint'($signed({m_insn[31], m_insn[7], m_insn[30:25], m_insn[11:8], 1'b0}));
            return imm < 0 ? m_base + 64'(imm) : m_base + 64'd4;
        end
        if (m_insn[6:0] == 7'h67) return btb_or_seq;
        return m_base + 64'd4;
    endfunction
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_valid = 1'b0; m_active = 1'b0; m_pc = '0; e = 0;
            for (int i = 0; i < N; i++) bv[i] = 1'b0;
        end else begin
            e++;
            if (bus.miss) begin
                m_base = bus.pc_curr; m_insn = bus.insn_curr; m_ivld = 1'b1;
                due = e + WP; m_active = 1'b1; m_valid = 1'b0;
            end else if (m_valid && bus.pc_pre_ready) begin
                m_base = m_pc; m_ivld = 1'b0; due = e + WP; m_valid = 1'b0;
            end else if (m_active && !m_valid && e == due) begin
                m_pc = predict(); m_valid = 1'b1;
            end
            if (bus.upd_valid) begin
                bv[int'(bus.upd_pc[5:2])]  = 1'b1;
                bpc[int'(bus.upd_pc[5:2])] = bus.upd_pc;
                btg[int'(bus.upd_pc[5:2])] = bus.upd_target;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("model_valid", 64'(bus.pc_pre_valid), 64'(m_valid));
            chk("model_pc_pre", bus.pc_pre, m_valid ? m_pc : 64'd0);
            chk("model_busy", 64'(bus.busy), 64'(m_active && !m_valid));
        end
    end
    task automatic do_miss(input logic [63:0] pc, input logic [31:0] insn, input logic rdy);
        @(negedge clk);
        bus.miss = 1'b1; bus.pc_curr = pc; bus.insn_curr = insn; bus.pc_pre_ready = rdy;
        @(negedge clk);
        bus.miss = 1'b0; bus.pc_pre_ready = 1'b0;
    endtask
    task automatic wait_valid(output int cyc, output int busy_n);
        cyc = 0; busy_n = 0;
        while (!bus.pc_pre_valid && cyc < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask
    task automatic check_pred(input string name, input logic [63:0] exp);
        int c, b;
        wait_valid(c, b);
        chk({name, "_latency"}, 64'(c), 64'(WP));
        chk(name, bus.pc_pre, exp);
    endtask
    function automatic logic [63:0] pool();
        logic [63:0] b [4];
        b = '{64'h4000, 64'h8040, 64'hFFFF_FFFF_FFFF_FFC0, 64'h1234_5678_0000_0000};
        return b[$urandom_range(0, 3)] + 64'($urandom_range(0, 31) << 1);
    endfunction
    initial begin
        int          c, b;
        logic        ok;
        logic [31:0] r;
        bus.miss = 0; bus.pc_curr = '0; bus.insn_curr = '0; bus.upd_valid = 0;
        bus.upd_pc = '0; bus.upd_target = '0; bus.pc_pre_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.pc_pre_valid), 64'd0);
        chk("rst_pc_pre", bus.pc_pre, 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        do_miss(64'h1000, 32'h0000_0013, 1'b0);
        wait_valid(c, b);
        chk("seq_latency", 64'(c), 64'd6);
        chk("seq_busy_cycles", 64'(b), 64'd6);
        chk("seq_pc", bus.pc_pre, 64'h1004);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.pc_pre_valid || bus.pc_pre != 64'h1004) ok = 1'b0;
        end
        chk("hold_stable", 64'(ok), 64'd1);
        do_miss(64'h2000, 32'h0080_006F, 1'b0);
        check_pred("jal", 64'h2008);
        do_miss(64'h3004, 32'hFE00_0EE3, 1'b0);
        check_pred("branch_back", 64'h3000);
        do_miss(64'h3000, 32'h0000_0463, 1'b0);
        check_pred("branch_fwd", 64'h3004);
        @(negedge clk);
        bus.upd_valid = 1'b1; bus.upd_pc = 64'h4000; bus.upd_target = 64'h5000;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        do_miss(64'h4000, 32'h0000_8067, 1'b0);
        check_pred("jalr_hit", 64'h5000);
        @(negedge clk);
        bus.pc_pre_ready = 1'b1;
        @(negedge clk);
        bus.pc_pre_ready = 1'b0;
        check_pred("chained", 64'h5004);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.pc_pre_valid), 64'd0);
        chk("async_rst_pc_pre", bus.pc_pre, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_miss(64'h4000, 32'h0000_8067, 1'b0);
        check_pred("jalr_after_rst", 64'h4004);
        do_miss(64'h1000, 32'h0000_0013, 1'b0);
        @(negedge clk);
        do_miss(64'h8000, 32'h0000_0013, 1'b0);
        check_pred("abort", 64'h8004);
        do_miss(64'h2000, 32'h0080_006F, 1'b1);
        check_pred("miss_beats_ready", 64'h2008);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 1500) rst_n = 1'b0;
            if (k == 1502) rst_n = 1'b1;
            r = $urandom;
            case ($urandom_range(0, 5))
                0: r[1:0] = 2'($urandom_range(0, 2));
                1: r[6:0] = 7'h6F;
                2: r[6:0] = 7'h63;
                3: r[6:0] = 7'h67;
                4: r[1:0] = 2'b11;
                default: r = 32'h0000_0013;
            endcase
            bus.miss         = ($urandom_range(0, 9) == 0);
            bus.pc_curr      = pool();
            bus.insn_curr    = r;
            bus.upd_valid    = ($urandom_range(0, 3) == 0);
            bus.upd_pc       = pool();
            bus.upd_target   = {$urandom, $urandom};
            bus.pc_pre_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.miss = 0; bus.upd_valid = 0; bus.pc_pre_ready = 0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
